pram_loader: RTL and testbench

//  - Writer side of the program RAM: the CPU core only reads p_ram (wren tied 0); this block fills it.
//  - Consumes a byte stream from a UART receiver at clk_in, assembles little-endian 16-bit words, writes them to p_ram.
//  - Holds the CPU (hold_cpu ORed into the core's init path at top level) until a complete valid image is loaded.

---
 rtl/xm23_loader_pkg.sv | 34 +++
 rtl/loader_byte_timer.sv | 37 +++
 rtl/pram_loader.sv | 179 +++++++++++++++++
 tb/tb_pram_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xm23_loader_pkg.sv
// Shared types for the program-RAM loader: FSM states and frame layout.
// Optional checksum field is enabled with PRAM_LOADER_CKSUM_EN.
package xm23_loader_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  // Frame field order, also used as the state encoding.
  localparam logic [3:0] FLD_SYNC    = 4'd0;
  localparam logic [3:0] FLD_ADDR_LO = 4'd1;
  localparam logic [3:0] FLD_ADDR_HI = 4'd2;
  localparam logic [3:0] FLD_CNT_LO  = 4'd3;
  localparam logic [3:0] FLD_CNT_HI  = 4'd4;
  localparam logic [3:0] FLD_DATA_LO = 4'd5;
  localparam logic [3:0] FLD_DATA_HI = 4'd6;
`ifdef PRAM_LOADER_CKSUM_EN
  localparam logic [3:0] FLD_CKSUM   = 4'd7;
`endif

  typedef enum logic [3:0] {
    ST_IDLE    = FLD_SYNC,
    ST_ADDR_LO = FLD_ADDR_LO,
    ST_ADDR_HI = FLD_ADDR_HI,
    ST_CNT_LO  = FLD_CNT_LO,
    ST_CNT_HI  = FLD_CNT_HI,
    ST_DATA_LO = FLD_DATA_LO,
    ST_DATA_HI = FLD_DATA_HI,
`ifdef PRAM_LOADER_CKSUM_EN
    ST_CKSUM   = FLD_CKSUM,
`endif
    ST_DONE    = 4'd8,
    ST_ERR     = 4'd9
  } loader_state_t;

endpackage

// File: rtl/loader_byte_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags expiry.
module loader_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk_in,
  input  logic init,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires in the last idle cycle so the owner leaves on that edge.
  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (init) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pram_loader.sv
// Program-RAM writer: parses a UART byte frame, writes 16-bit words.
// Define PRAM_LOADER_CKSUM_EN to require a trailing checksum byte.
module pram_loader
  import xm23_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int unsigned ADDR_W         = 15
) (
  input  logic              clk_in,
  input  logic              init,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] pram_address,
  output logic [15:0]       pram_data,
  output logic              pram_wren,
  output logic              hold_cpu,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_written
);

`ifdef PRAM_LOADER_CKSUM_EN
  localparam loader_state_t ST_LAST = ST_CKSUM;
`else
  localparam loader_state_t ST_LAST = ST_DONE;
`endif

  loader_state_t state_q, state_d;

  logic [7:0]        byte_q, byte_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [15:0]       words_q, words_d;
`ifdef PRAM_LOADER_CKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  logic active;
  logic tmr_expired;

  assign active = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});

  loader_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in  (clk_in),
    .init    (init),
    .clr     (rx_valid || !active),
    .en      (active),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d   = words_q;
`ifdef PRAM_LOADER_CKSUM_EN
    acc_d     = acc_q;
`endif
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          byte_d  = rx_data;
          state_d = ST_ADDR_HI;
        end
        ST_ADDR_HI: begin
          if (byte_q[0]) begin
            state_d = ST_ERR;
          end else begin
            addr_d  = ADDR_W'({rx_data, byte_q[7:1]});
            state_d = ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          byte_d  = rx_data;
          state_d = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          cnt_d = {rx_data, byte_q};
          if ({rx_data, byte_q} == 16'd0) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          byte_d  = rx_data;
          state_d = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          // Write register is separate from byte capture, so the
          // next byte may arrive while the write is on the bus.
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {rx_data, byte_q};
          addr_d    = addr_q + ADDR_W'(1);
          words_d   = words_q + 16'd1;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_DATA_LO;
          end
        end
`ifdef PRAM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (rx_data == acc_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
`ifdef PRAM_LOADER_CKSUM_EN
      if (state_q inside {ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO,
                          ST_CNT_HI, ST_DATA_LO, ST_DATA_HI}) begin
        acc_d = acc_q + rx_data;
      end
`endif
    end else if (active && tmr_expired) begin
      state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk_in) begin
    if (init) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
`ifdef PRAM_LOADER_CKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
`ifdef PRAM_LOADER_CKSUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign pram_address  = wr_addr_q;
  assign pram_data     = wr_data_q;
  assign pram_wren     = wr_en_q;
  assign words_written = words_q;
  assign load_done     = (state_q == ST_DONE);
  assign load_error    = (state_q == ST_ERR);
  assign hold_cpu      = (state_q != ST_DONE);

endmodule

// File: tb/tb_pram_loader.sv
// Randomized bench for pram_loader against a frame-level reference model.
// Build with or without PRAM_LOADER_CKSUM_EN.
module tb_pram_loader;

  localparam int TMO = 100;

  logic        clk;
  logic        init;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [14:0] pram_address;
  logic [15:0] pram_data;
  logic        pram_wren;
  logic        hold_cpu;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_written;

  int total = 0;
  int bad   = 0;

  logic [30:0] wq[$];

  pram_loader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in        (clk),
    .init          (init),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .pram_address  (pram_address),
    .pram_data     (pram_data),
    .pram_wren     (pram_wren),
    .hold_cpu      (hold_cpu),
    .load_done     (load_done),
    .load_error    (load_error),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pram_wren) wq.push_back({pram_address, pram_data});
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    init     = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    init = 1'b0;
    wq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".wren"}, {31'd0, pram_wren}, 32'd0);
    chk({tag, ".addr"}, {17'd0, pram_address}, 32'd0);
    chk({tag, ".data"}, {16'd0, pram_data}, 32'd0);
    chk({tag, ".hold"}, {31'd0, hold_cpu}, 32'd1);
    chk({tag, ".done"}, {31'd0, load_done}, 32'd0);
    chk({tag, ".err"}, {31'd0, load_error}, 32'd0);
    chk({tag, ".words"}, {16'd0, words_written}, 32'd0);
  endtask

  // Byte after 0..maxgap idle cycles; returns at the negedge after the strobe.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [15:0] baddr,
                            input logic [15:0] w[$], input bit bad_ck);
    logic [7:0] body[$];
    logic [7:0] ck;
    ck = 8'h00;
    body.push_back(baddr[7:0]);
    body.push_back(baddr[15:8]);
    body.push_back(8'(w.size()));
    body.push_back(8'(w.size() >> 8));
    foreach (w[i]) begin
      body.push_back(w[i][7:0]);
      body.push_back(w[i][15:8]);
    end
    send_byte(8'hA5, 3);
    foreach (body[i]) begin
      send_byte(body[i], 3);
      ck = ck + body[i];
    end
`ifdef PRAM_LOADER_CKSUM_EN
    send_byte(bad_ck ? (ck ^ 8'h5A) : ck, 3);
`else
    if (bad_ck) ck = 8'h00;
`endif
  endtask

  // Expected result derived from frame contents alone.
  task automatic check_frame(input string tag, input logic [15:0] baddr,
                             input logic [15:0] w[$], input bit bad_ck);
    bit odd, ok;
    int nexp;
    logic [14:0] ea;
    odd = baddr[0];
`ifdef PRAM_LOADER_CKSUM_EN
    ok = !odd && !bad_ck;
`else
    ok = !odd;
`endif
    nexp = odd ? 0 : w.size();
    repeat (3) @(negedge clk);
    chk({tag, ".nwr"}, 32'(wq.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wq.size(); i++) begin
      ea = 15'((baddr >> 1) + i);
      chk({tag, ".wa"}, {17'd0, wq[i][30:16]}, {17'd0, ea});
      chk({tag, ".wd"}, {16'd0, wq[i][15:0]}, {16'd0, w[i]});
    end
    chk({tag, ".done"}, {31'd0, load_done}, {31'd0, ok});
    chk({tag, ".err"}, {31'd0, load_error}, {31'd0, !ok});
    chk({tag, ".hold"}, {31'd0, hold_cpu}, {31'd0, !ok});
    chk({tag, ".words"}, {16'd0, words_written}, 32'(nexp));
  endtask

  initial begin
    logic [15:0] w[$];
    logic [15:0] ba;
    bit          bc;
    int          n;
    init     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    init = 1'b0;
    wq.delete();

    // Reference image
    w = '{16'h1234, 16'h5678};
    send_frame(16'h0000, w, 1'b0);
    check_frame("basic", 16'h0000, w, 1'b0);

    // Sticky DONE: a second frame is ignored
    wq.delete();
    w = '{16'hDEAD};
    send_frame(16'h0010, w, 1'b0);
    repeat (3) @(negedge clk);
    chk("sticky.nwr", 32'(wq.size()), 32'd0);
    chk("sticky.done", {31'd0, load_done}, 32'd1);
    chk("sticky.words", {16'd0, words_written}, 32'd2);

    // Garbage before sync, odd byte address
    do_reset();
    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    chk("garb.err", {31'd0, load_error}, 32'd0);
    w = '{16'hAAAA, 16'hBBBB};
    send_frame(16'h0001, w, 1'b0);
    check_frame("odd", 16'h0001, w, 1'b0);

    // Address wrap
    do_reset();
    w = '{16'($urandom), 16'($urandom)};
    send_frame(16'hFFFE, w, 1'b0);
    check_frame("wrap", 16'hFFFE, w, 1'b0);

    // Timeout after the first data byte
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h77, 0);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo.early", {31'd0, load_error}, 32'd0);
    @(negedge clk);
    chk("tmo.err", {31'd0, load_error}, 32'd1);
    chk("tmo.hold", {31'd0, hold_cpu}, 32'd1);
    chk("tmo.nwr", 32'(wq.size()), 32'd0);

    // Reset mid-DATA, then a full frame
    do_reset();
    w = '{16'h0102, 16'h0304, 16'h0506};
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    init = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    init = 1'b0;
    wq.delete();
    send_frame(16'h0020, w, 1'b0);
    check_frame("reload", 16'h0020, w, 1'b0);

    // Reset wins over a same-cycle sync byte
    @(negedge clk);
    init     = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    init     = 1'b0;
    rx_valid = 1'b0;
    wq.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (TMO + 5) @(negedge clk);
    chk("rstwin.nwr", 32'(wq.size()), 32'd0);
    chk("rstwin.err", {31'd0, load_error}, 32'd0);
    chk("rstwin.done", {31'd0, load_done}, 32'd0);

    // Empty image
    do_reset();
    w = {};
    send_frame(16'h0100, w, 1'b0);
    check_frame("n0", 16'h0100, w, 1'b0);

`ifdef PRAM_LOADER_CKSUM_EN
    do_reset();
    w = '{16'h1234, 16'h5678};
    send_frame(16'h0000, w, 1'b1);
    check_frame("badck", 16'h0000, w, 1'b1);
`endif

    // Random frames
    for (int k = 0; k < 12; k++) begin
      do_reset();
      w = {};
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      ba = 16'($urandom);
      if ($urandom_range(3, 0) != 0) ba[0] = 1'b0;
      bc = ($urandom_range(3, 0) == 0);
      send_frame(ba, w, bc);
      check_frame("rand", ba, w, bc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
